// File: rtl/ifft8_pkg.sv
// ifft8_pkg: shared definitions for the 8-point inverse FFT core.
//   - default sample width and twiddle precision
//   - Q16 twiddle table for W^-t = cos(2*pi*t/8) + j*sin(2*pi*t/8), t = 0..3
//   - FSM state encoding and the control struct that carries the FSM state
//     and all counters (one place to probe the controller)
//   - bitrev3 helper for the decimation-in-time input ordering
package ifft8_pkg;

  localparam int W_DEF       = 32;
  localparam int TW_FRAC_DEF = 16;
  // 65536 (1.0 in Q16) needs 17 magnitude bits plus sign
  localparam int TW_W        = 18;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } ifft8_state_e;

  typedef struct packed {
    ifft8_state_e state;
    logic [2:0]   k;       // input bin index (LOAD)
    logic [1:0]   stage;   // 0..2, span = 1 << stage
    logic [1:0]   bfly;    // butterfly index within the stage
    logic         phase;   // 0 = issue, 1 = writeback
    logic [2:0]   n;       // output sample index (UNLOAD)
    logic         ovalid;  // registered out_valid
  } ifft8_ctl_t;

  function automatic logic signed [TW_W-1:0] tw_cos(input logic [1:0] idx);
    case (idx)
      2'd0:    return 18'sd65536;
      2'd1:    return 18'sd46341;
      2'd2:    return 18'sd0;
      default: return -18'sd46341;
    endcase
  endfunction

  function automatic logic signed [TW_W-1:0] tw_sin(input logic [1:0] idx);
    case (idx)
      2'd0:    return 18'sd0;
      2'd1:    return 18'sd46341;
      2'd2:    return 18'sd65536;
      default: return 18'sd46341;
    endcase
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/ifft8_core_bfly.sv
// ifft_butterfly: registered radix-2 inverse butterfly.
//   c = a + b*W^-t, d = a - b*W^-t, both saturated to W bits.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   issue                operands valid this cycle; results register on the edge
//   tw_idx[1:0]          twiddle index t
//   a_re/a_im, b_re/b_im operands (signed W bits)
//   c_re/c_im, d_re/d_im registered results
//   done                 high the cycle after issue
module ifft_butterfly
  import ifft8_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TW_FRAC = TW_FRAC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic [1:0]          tw_idx,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W-1:0] c_re,
  output logic signed [W-1:0] c_im,
  output logic signed [W-1:0] d_re,
  output logic signed [W-1:0] d_im,
  output logic                done
);

  // W+17 bits holds |b| * 2^16 and the sum of two such products, and the
  // shifted twiddle product plus a, so one width carries the whole datapath.
  localparam int PW = W + 17;

  localparam logic signed [PW-1:0] MAX_X = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_X = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [TW_W-1:0] cw, sw;
  logic signed [PW-1:0]   a_re_x, a_im_x, b_re_x, b_im_x, cos_x, sin_x;
  logic signed [PW-1:0]   p_rc, p_is, p_rs, p_ic, acc_re, acc_im;
  logic signed [PW-1:0]   t_re, t_im;
  logic signed [PW-1:0]   c_re_x, c_im_x, d_re_x, d_im_x;

  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAX_X)      return {1'b0, {(W-1){1'b1}}};
    else if (v < MIN_X) return {1'b1, {(W-1){1'b0}}};
    else                return v[W-1:0];
  endfunction

  assign cw     = tw_cos(tw_idx);
  assign sw     = tw_sin(tw_idx);
  assign cos_x  = {{(PW-TW_W){cw[TW_W-1]}}, cw};
  assign sin_x  = {{(PW-TW_W){sw[TW_W-1]}}, sw};
  assign a_re_x = {{(PW-W){a_re[W-1]}}, a_re};
  assign a_im_x = {{(PW-W){a_im[W-1]}}, a_im};
  assign b_re_x = {{(PW-W){b_re[W-1]}}, b_re};
  assign b_im_x = {{(PW-W){b_im[W-1]}}, b_im};

  assign p_rc   = b_re_x * cos_x;
  assign p_is   = b_im_x * sin_x;
  assign p_rs   = b_re_x * sin_x;
  assign p_ic   = b_im_x * cos_x;
  assign acc_re = p_rc - p_is;
  assign acc_im = p_rs + p_ic;

  // t = 0 passes b through untouched so the unity twiddle adds no floor error
  assign t_re   = (tw_idx == 2'd0) ? b_re_x : (acc_re >>> TW_FRAC);
  assign t_im   = (tw_idx == 2'd0) ? b_im_x : (acc_im >>> TW_FRAC);

  assign c_re_x = a_re_x + t_re;
  assign c_im_x = a_im_x + t_im;
  assign d_re_x = a_re_x - t_re;
  assign d_im_x = a_im_x - t_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_re <= '0;
      c_im <= '0;
      d_re <= '0;
      d_im <= '0;
      done <= 1'b0;
    end else begin
      done <= issue;
      if (issue) begin
        c_re <= sat(c_re_x);
        c_im <= sat(c_im_x);
        d_re <= sat(d_re_x);
        d_im <= sat(d_im_x);
      end
    end
  end

endmodule

// File: rtl/ifft8_core.sv
// ifft8_core: 8-point radix-2 DIT inverse FFT, one time-shared butterfly.
//   LOAD    : accept 8 bins (k = 0..7), store at bitrev3(k)
//   COMPUTE : 3 stages (span 1, 2, 4) x 4 butterflies x 2 cycles = 24 cycles
//   UNLOAD  : stream x[0..7] in natural order, out_last with x[7]
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready, in_re/im input bin stream
//   out_valid/out_ready, out_re/im, out_last  output sample stream
//   busy                        high in COMPUTE or UNLOAD
// Handshake: a transfer happens on a rising edge where valid && ready; the
// source holds data stable and keeps valid high until then, and ready may
// depend on state only (never on the partner's valid).
module ifft8_core
  import ifft8_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TW_FRAC = TW_FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_last,
  output logic         busy
);

  logic signed [W-1:0] buf_re [8];
  logic signed [W-1:0] buf_im [8];

  ifft8_ctl_t ctl_q, ctl_d;

  logic       in_fire, out_fire, last_bfly, bf_issue, bf_done, wb_en, out_load;
  logic [2:0] top_addr, bot_addr, out_sel;
  logic [1:0] tw_idx;
  logic signed [W-1:0] c_re, c_im, d_re, d_im;

  assign in_ready  = (ctl_q.state == ST_LOAD);
  assign busy      = (ctl_q.state != ST_LOAD);
  assign out_valid = ctl_q.ovalid;
  assign out_last  = ctl_q.ovalid && (ctl_q.n == 3'd7);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_bfly = (ctl_q.stage == 2'd2) && (ctl_q.bfly == 2'd3);
  assign bf_issue  = (ctl_q.state == ST_COMPUTE) && !ctl_q.phase;
  assign wb_en     = (ctl_q.state == ST_COMPUTE) && bf_done;

  // Pair and twiddle for butterfly j at span s = 1 << stage:
  // top = (j/s)*2s + j%s, bottom = top + s, t = (j%s)*(4/s).
  always_comb begin
    top_addr = '0;
    bot_addr = '0;
    tw_idx   = '0;
    case (ctl_q.stage)
      2'd0: begin
        top_addr = {ctl_q.bfly, 1'b0};
        bot_addr = {ctl_q.bfly, 1'b1};
        tw_idx   = 2'd0;
      end
      2'd1: begin
        top_addr = {ctl_q.bfly[1], 1'b0, ctl_q.bfly[0]};
        bot_addr = {ctl_q.bfly[1], 1'b1, ctl_q.bfly[0]};
        tw_idx   = {ctl_q.bfly[0], 1'b0};
      end
      default: begin
        top_addr = {1'b0, ctl_q.bfly};
        bot_addr = {1'b1, ctl_q.bfly};
        tw_idx   = ctl_q.bfly;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctl_q <= '0;
    else        ctl_q <= ctl_d;
  end

  always_comb begin
    ctl_d    = ctl_q;
    out_load = 1'b0;
    out_sel  = ctl_q.n;
    case (ctl_q.state)
      ST_LOAD: begin
        if (in_fire) begin
          ctl_d.k = ctl_q.k + 3'd1;
          if (ctl_q.k == 3'd7) begin
            ctl_d.state = ST_COMPUTE;
            ctl_d.stage = 2'd0;
            ctl_d.bfly  = 2'd0;
            ctl_d.phase = 1'b0;
          end
        end
      end
      ST_COMPUTE: begin
        ctl_d.phase = ~ctl_q.phase;
        if (ctl_q.phase) begin
          if (last_bfly) begin
            ctl_d.state  = ST_UNLOAD;
            ctl_d.n      = 3'd0;
            ctl_d.ovalid = 1'b0;
          end else begin
            ctl_d.bfly = ctl_q.bfly + 2'd1;
            if (ctl_q.bfly == 2'd3) ctl_d.stage = ctl_q.stage + 2'd1;
          end
        end
      end
      ST_UNLOAD: begin
        // First UNLOAD cycle only primes the output register with x[0].
        if (!ctl_q.ovalid) begin
          ctl_d.ovalid = 1'b1;
          out_load     = 1'b1;
          out_sel      = ctl_q.n;
        end else if (out_fire) begin
          if (ctl_q.n == 3'd7) begin
            ctl_d.state  = ST_LOAD;
            ctl_d.ovalid = 1'b0;
            ctl_d.n      = 3'd0;
          end else begin
            ctl_d.n  = ctl_q.n + 3'd1;
            out_load = 1'b1;
            out_sel  = ctl_q.n + 3'd1;
          end
        end
      end
      default: begin
        ctl_d       = '0;
        ctl_d.state = ST_LOAD;
      end
    endcase
  end

  ifft_butterfly #(.W(W), .TW_FRAC(TW_FRAC)) u_bfly (
    .clk    (clk),
    .rst_n  (rst_n),
    .issue  (bf_issue),
    .tw_idx (tw_idx),
    .a_re   (buf_re[top_addr]),
    .a_im   (buf_im[top_addr]),
    .b_re   (buf_re[bot_addr]),
    .b_im   (buf_im[bot_addr]),
    .c_re   (c_re),
    .c_im   (c_im),
    .d_re   (d_re),
    .d_im   (d_im),
    .done   (bf_done)
  );

  // Working buffer: no reset needed, every frame fully overwrites it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_re[bitrev3(ctl_q.k)] <= in_re;
      buf_im[bitrev3(ctl_q.k)] <= in_im;
    end else if (wb_en) begin
      buf_re[top_addr] <= c_re;
      buf_im[top_addr] <= c_im;
      buf_re[bot_addr] <= d_re;
      buf_im[bot_addr] <= d_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_re <= '0;
      out_im <= '0;
    end else if (out_load) begin
      out_re <= buf_re[out_sel];
      out_im <= buf_im[out_sel];
    end
  end

endmodule

// File: tb/tb_ifft8_core.sv
// Directed testbench for ifft8_core: impulse (with latency), single tone,
// backpressure, positive/negative saturation, DFT round trip and reset
// in the middle of COMPUTE.
module tb_ifft8_core;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0] in_re, in_im, out_re, out_im;

  always #5 clk = ~clk;

  ifft8_core #(.W(W), .TW_FRAC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  longint       bin_re [8];
  longint       bin_im [8];
  longint       got_re [8];
  longint       got_im [8];
  logic         got_last [8];
  logic [W-1:0] exp_re_q [$];
  logic [W-1:0] exp_im_q [$];

  task automatic check(input string tag, input longint obs, input longint exp,
                       input longint tol = 0);
    longint diff;
    checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint sv(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    else          return -longint'($rtoi(-r + 0.5));
  endfunction

  task automatic clear_bins();
    for (int i = 0; i < 8; i++) begin
      bin_re[i] = 0;
      bin_im[i] = 0;
    end
  endtask

  task automatic push_exp(input longint re, input longint im);
    exp_re_q.push_back(W'(re));
    exp_im_q.push_back(W'(im));
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame();
    int wait_cyc;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_re    = W'(bin_re[k]);
      in_im    = W'(bin_im[k]);
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 200) begin
        @(posedge clk); #1;
        wait_cyc++;
      end
      if (!in_ready) begin
        check("send_ready", longint'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  // bp = 0: always ready; bp = 1: ready pattern 1,0,0,1,0,0,...
  task automatic recv_frame(input int bp);
    int           idx, cyc;
    logic         stalled, rdy;
    logic [W-1:0] held_re, held_im;
    idx = 0; cyc = 0; stalled = 1'b0; held_re = '0; held_im = '0;
    while (idx < 8 && cyc < 400) begin
      rdy       = (bp == 0) ? 1'b1 : ((cyc % 3) == 0);
      out_ready = rdy;
      if (out_valid) begin
        if (stalled) begin
          check("hold_re", sv(out_re), sv(held_re));
          check("hold_im", sv(out_im), sv(held_im));
        end
        check("in_ready_unload", longint'(in_ready), 0);
        if (rdy) begin
          got_re[idx]   = sv(out_re);
          got_im[idx]   = sv(out_im);
          got_last[idx] = out_last;
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_re = out_re;
          held_im = out_im;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    check("recv_count", idx, 8);
    check("in_ready_after", longint'(in_ready), 1);
    check("busy_after", longint'(busy), 0);
  endtask

  task automatic compare_frame(input string name, input longint tol);
    logic [W-1:0] er, ei;
    for (int i = 0; i < 8; i++) begin
      er = exp_re_q.pop_front();
      ei = exp_im_q.pop_front();
      check($sformatf("%s_re%0d", name, i), got_re[i], sv(er), tol);
      check($sformatf("%s_im%0d", name, i), got_im[i], sv(ei), tol);
      check($sformatf("%s_last%0d", name, i), longint'(got_last[i]), longint'(i == 7));
    end
  endtask

  task automatic set_tone();
    clear_bins();
    bin_re[1] = 65536;
  endtask

  task automatic push_tone_exp();
    push_exp( 65536,      0);
    push_exp( 46341,  46341);
    push_exp(     0,  65536);
    push_exp(-46341,  46341);
    push_exp(-65536,      0);
    push_exp(-46341, -46341);
    push_exp(     0, -65536);
    push_exp( 46341, -46341);
  endtask

  task automatic run_impulse(input string name);
    clear_bins();
    bin_re[0] = 1000;
    send_frame();
    recv_frame(0);
    for (int i = 0; i < 8; i++) push_exp(1000, 0);
    compare_frame(name, 0);
  endtask

  // ---------------- main sequence ----------------
  longint ts_re [8];
  longint ts_im [8];

  initial begin
    int  lat;
    real ang, sr, si, pi;
    pi        = 3.14159265358979;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_out_re", sv(out_re), 0);
    check("rst_out_im", sv(out_im), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse with latency measurement
    clear_bins();
    bin_re[0] = 1000;
    send_frame();
    check("compute_in_ready", longint'(in_ready), 0);
    check("compute_busy", longint'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 25);
    recv_frame(0);
    for (int i = 0; i < 8; i++) push_exp(1000, 0);
    compare_frame("impulse", 0);

    // Single tone at bin 1
    set_tone();
    send_frame();
    recv_frame(0);
    push_tone_exp();
    compare_frame("tone", 2);

    // Same tone under backpressure
    set_tone();
    send_frame();
    recv_frame(1);
    push_tone_exp();
    compare_frame("bp_tone", 2);

    // Positive saturation
    for (int i = 0; i < 8; i++) begin
      bin_re[i] = 64'sd2147483647;
      bin_im[i] = 0;
    end
    send_frame();
    recv_frame(0);
    push_exp(64'sd2147483647, 0);
    for (int i = 1; i < 8; i++) push_exp(0, 0);
    compare_frame("sat_pos", 0);

    // Negative saturation
    for (int i = 0; i < 8; i++) begin
      bin_re[i] = -64'sd2147483648;
      bin_im[i] = 0;
    end
    send_frame();
    recv_frame(0);
    push_exp(-64'sd2147483648, 0);
    for (int i = 1; i < 8; i++) push_exp(0, 0);
    compare_frame("sat_neg", 0);

    // Round trip: scaled forward DFT of a time sequence, expect originals back
    ts_re = '{123456, -654321, 1000000, -1, 777777, -900000, 42, 314159};
    ts_im = '{-271828, 500000, -999999, 12345, 0, 654321, -111111, 888888};
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        ang = 2.0 * pi * real'(k * n) / 8.0;
        sr  = sr + real'(ts_re[n]) * $cos(ang) + real'(ts_im[n]) * $sin(ang);
        si  = si + real'(ts_im[n]) * $cos(ang) - real'(ts_re[n]) * $sin(ang);
      end
      bin_re[k] = rnd(sr / 8.0);
      bin_im[k] = rnd(si / 8.0);
    end
    send_frame();
    recv_frame(0);
    for (int i = 0; i < 8; i++) push_exp(ts_re[i], ts_im[i]);
    compare_frame("roundtrip", 8);

    // Reset at cycle 10 of COMPUTE; output regs still hold the last roundtrip sample
    set_tone();
    send_frame();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_out_last", longint'(out_last), 0);
    check("midrst_out_re", sv(out_re), 0);
    check("midrst_out_im", sv(out_im), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_impulse("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
